cgp_fitness_eval: RTL and testbench

Hardware fitness evaluator for evolved CGP candidate circuits. It drives every input pattern into a combinational candidate, waits a programmable settle time, and compares the candidate output against a target truth table. It counts the matching patterns and reports the score with a done pulse. It sits between the evolution controller and the candidate under evaluation, replacing the software truth-table sweep in the evolution loop.

---
 rtl/cgp_fitness_eval_pkg.sv | 6 +
 rtl/cgp_fitness_eval_if.sv | 16 +
 rtl/cgp_fitness_eval.sv | 71 +++++++
 tb/tb_cgp_fitness_eval.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/cgp_fitness_eval_pkg.sv
// cgp_eval_pkg: shared evaluator state type and default sizing constants
package cgp_eval_pkg;
    localparam int CGP_N_IN   = 4;
    localparam int CGP_SETTLE = 2;
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} eval_state_t;
endpackage

// File: rtl/cgp_fitness_eval_if.sv
// cgp_fitness_eval_if: controller-side start/abort/result bundle of the fitness evaluator
interface cgp_fitness_eval_if
    import cgp_eval_pkg::*;
#(
    parameter int N_IN = CGP_N_IN
);
    logic              start;
    logic              abort;
    logic [2**N_IN-1:0] target_tt;
    logic              busy;
    logic              done;
    logic [N_IN:0]     score;
    logic              perfect;
    modport master (output start, abort, target_tt, input busy, done, score, perfect);
    modport slave  (input start, abort, target_tt, output busy, done, score, perfect);
endinterface

// File: rtl/cgp_fitness_eval.sv
// cgp_fitness_eval: sweeps all input patterns through a candidate and scores it against a truth table
module cgp_fitness_eval
    import cgp_eval_pkg::*;
#(
    parameter int N_IN   = CGP_N_IN,
    parameter int SETTLE = CGP_SETTLE
) (
    input  logic                clk,
    input  logic                rst_n,
    cgp_fitness_eval_if.slave   ctl,
    output logic [N_IN-1:0]     cand_in,
    input  logic                cand_out
);
    localparam int NP = 2**N_IN;
    localparam int CW = $clog2(SETTLE + 1);

    eval_state_t   state, nxt;
    logic [CW-1:0] cnt;
    logic [NP-1:0] tt_q;
    logic [N_IN:0] nscore;
    logic          match, last, settled, accept, kill;

    // cand_in doubles as the pattern index; X on cand_out counts as a mismatch
    assign match   = cand_out === tt_q[cand_in];
    assign last    = &cand_in;
    assign settled = cnt == CW'(SETTLE - 1);
    assign accept  = state == S_IDLE && ctl.start && !ctl.abort;
    assign kill    = (state == S_SETTLE || state == S_SAMPLE) && ctl.abort;
    assign nscore  = ctl.score + (N_IN + 1)'(match);
    assign ctl.busy = state != S_IDLE;
    assign ctl.done = state == S_DONE;

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;

    // next state: abort wins in the sweep states, DONE always returns to IDLE
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = accept ? S_SETTLE : S_IDLE;
            S_SETTLE: nxt = ctl.abort ? S_IDLE : settled ? S_SAMPLE : S_SETTLE;
            S_SAMPLE: nxt = ctl.abort ? S_IDLE : last ? S_DONE : S_SETTLE;
            default:  nxt = S_IDLE;
        endcase
    end

    // datapath: capture on start, count settle cycles, accumulate score on sample
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tt_q        <= '0;
            cnt         <= '0;
            cand_in     <= '0;
            ctl.score   <= '0;
            ctl.perfect <= 1'b0;
        end else if (accept || kill) begin
            if (accept) tt_q <= ctl.target_tt;
            cnt         <= '0;
            cand_in     <= '0;
            ctl.score   <= '0;
            ctl.perfect <= 1'b0;
        end else if (state == S_SETTLE) begin
            cnt <= cnt + CW'(1);
        end else if (state == S_SAMPLE) begin
            cnt       <= '0;
            ctl.score <= nscore;
            cand_in   <= last ? '0 : cand_in + N_IN'(1);
            if (last) ctl.perfect <= nscore == (N_IN + 1)'(NP);
        end
endmodule

// File: tb/tb_cgp_fitness_eval.sv
// tb_cgp_fitness_eval: directed checks of the fitness evaluator with modelled candidates
module tb_cgp_fitness_eval;
    import cgp_eval_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] a_cand_in;
    logic       a_cand_out;
    logic [1:0] b_cand_in;
    logic       b_cand_out;
    int         mode;
    int         total = 0;
    int         bad = 0;

    cgp_fitness_eval_if #(.N_IN(4)) ia ();
    cgp_fitness_eval_if #(.N_IN(2)) ib ();

    cgp_fitness_eval #(.N_IN(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .ctl(ia), .cand_in(a_cand_in), .cand_out(a_cand_out));
    cgp_fitness_eval #(.N_IN(2), .SETTLE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .ctl(ib), .cand_in(b_cand_in), .cand_out(b_cand_out));

    assign a_cand_out = mode == 0 ? ^a_cand_in : mode == 1 ? 1'b0 : ~^a_cand_in;
    assign b_cand_out = ^b_cand_in;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_a(input logic [15:0] tt, input int m, input int poke,
                         output int lat, output logic [4:0] sc, output logic pf);
        int bad_steps = 0;
        mode = m;
        ia.target_tt = tt;
        ia.start = 1'b1;
        lat = 0;
        sc = '0;
        pf = 1'b0;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk); #1;
            ia.start = n == poke;
            if (ia.done) begin
                lat = n;
                sc = ia.score;
                pf = ia.perfect;
                if (!ia.busy) bad_steps++;
            end else if (a_cand_in !== 4'((n - 1) / 3) || !ia.busy) bad_steps++;
        end
        ia.start = 1'b0;
        chk("steps", bad_steps, 0);
    endtask

    task automatic watch_no_done(input string tag);
        int d = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (ia.done) d++;
        end
        chk(tag, d, 0);
    endtask

    initial begin
        int         lat;
        logic [4:0] sc;
        logic       pf;
        rst_n = 1'b0;
        mode = 0;
        ia.start = 1'b0; ia.abort = 1'b0; ia.target_tt = '0;
        ib.start = 1'b0; ib.abort = 1'b0; ib.target_tt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_score", ia.score, 0);
        chk("rst_perfect", ia.perfect, 0);
        chk("rst_cand_in", a_cand_in, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        run_a(16'h6996, 0, 0, lat, sc, pf);
        chk("xor_lat", lat, 49);
        chk("xor_score", sc, 16);
        chk("xor_perfect", pf, 1);
        @(posedge clk); #1;
        chk("post_busy", ia.busy, 0);
        chk("post_done", ia.done, 0);
        chk("post_score_hold", ia.score, 16);
        chk("post_perfect_hold", ia.perfect, 1);

        run_a(16'h6996, 1, 0, lat, sc, pf);
        chk("b2b_lat", lat, 49);
        chk("zero_score", sc, 8);
        chk("zero_perfect", pf, 0);
        @(posedge clk); #1;

        run_a(16'h6996, 2, 0, lat, sc, pf);
        chk("xnor_lat", lat, 49);
        chk("xnor_score", sc, 0);
        chk("xnor_perfect", pf, 0);
        @(posedge clk); #1;

        run_a(16'h6996, 0, 16, lat, sc, pf);
        chk("restart_lat", lat, 49);
        chk("restart_score", sc, 16);
        watch_no_done("restart_single_done");

        mode = 0;
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        chk("pre_abort_cand_in", a_cand_in, 7);
        chk("pre_abort_score", ia.score, 7);
        ia.abort = 1'b1;
        @(posedge clk); #1;
        ia.abort = 1'b0;
        chk("abort_busy", ia.busy, 0);
        chk("abort_score", ia.score, 0);
        chk("abort_cand_in", a_cand_in, 0);
        chk("abort_perfect", ia.perfect, 0);
        watch_no_done("abort_no_done");

        ia.start = 1'b1;
        ia.abort = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        ia.abort = 1'b0;
        chk("abort_start_busy", ia.busy, 0);
        @(posedge clk); #1;
        chk("abort_start_idle", ia.busy, 0);

        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        chk("pre_rst_score", ia.score, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", ia.busy, 0);
        chk("arst_score", ia.score, 0);
        chk("arst_cand_in", a_cand_in, 0);
        chk("arst_done", ia.done, 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        run_a(16'h6996, 0, 0, lat, sc, pf);
        chk("after_rst_lat", lat, 49);
        chk("after_rst_score", sc, 16);
        @(posedge clk); #1;

        ib.target_tt = 4'h6;
        ib.start = 1'b1;
        lat = 0;
        for (int n = 1; n <= 50 && lat == 0; n++) begin
            @(posedge clk); #1;
            ib.start = 1'b0;
            if (ib.done) begin
                lat = n;
                chk("b_score", ib.score, 4);
                chk("b_perfect", ib.perfect, 1);
            end
        end
        chk("b_lat", lat, 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
